compress_seq: RTL and testbench

COMPRESS_SEQ -- requirements
Module: compress_seq

---
 rtl/compress_seq.sv | 154 +++++++++++++++
 tb/tb_compress_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_seq.sv
// compress_seq: collects outmap beats in a 32-byte window for the compressor.
// The compressor's 64-bit packets pass through a one-entry slot and are
// written to sequential word addresses.
module compress_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       total_bytes,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic [4:0]        in_num,
  output logic [127:0]      cmp_data,
  output logic [4:0]        cmp_valid_num,
  output logic              cmp_start,
  input  logic [4:0]        cmp_taken,
  input  logic              cmp_mem_req,
  input  logic [63:0]       cmp_packet,
  output logic              cmp_mem_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [255:0]      buf_q, buf_d;
  logic [5:0]        occ_q, occ_d;
  logic [15:0]       total_q, rcvd_q, rcvd_d, remaining;
  logic              slot_full_q;
  logic [63:0]       slot_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       pkt_count_q;
  logic              cmp_start_q;

  logic              active, start_acc, beat_fire, wr_fire;
  logic [4:0]        taken, acc, num_lim;
  logic [5:0]        tail;
  logic [127:0]      beat_masked;
  logic [255:0]      placed;

  function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign active        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_acc     = start && (state_q == S_IDLE);
  assign in_ready      = (state_q == S_RUN) && (occ_q <= 6'd16) && (rcvd_q < total_q);
  assign beat_fire     = in_valid && in_ready;
  assign remaining     = total_q - rcvd_q;
  assign num_lim       = min5(in_num, 5'd16);
  // The last beat of a layer is cut to the bytes still owed.
  assign acc           = !beat_fire ? 5'd0 :
                         (remaining < {11'd0, num_lim}) ? remaining[4:0] : num_lim;
  assign cmp_valid_num = !active ? 5'd0 : (occ_q > 6'd16) ? 5'd16 : occ_q[4:0];
  assign taken         = min5(cmp_taken, cmp_valid_num);
  assign tail          = occ_q - {1'b0, taken};
  assign occ_d         = tail + {1'b0, acc};
  assign rcvd_d        = rcvd_q + {11'd0, acc};

  // Zero beat lanes beyond the accepted count so unused buffer bytes stay zero.
  always_comb begin
    beat_masked = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < acc) beat_masked[8*i +: 8] = in_data[8*i +: 8];
    end
  end

  // Consume from the bottom and append the new beat right after the survivors.
  always_comb begin
    placed = {128'd0, beat_masked} << {tail, 3'b000};
    buf_d  = (buf_q >> {taken, 3'b000}) | placed;
  end

  // Layer sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (rcvd_d == total_q) state_d = S_DRAIN;
      S_DRAIN: if ((occ_q == 6'd0) && !cmp_mem_req && !slot_full_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmp_mem_ack = cmp_mem_req && (!slot_full_q || wr_ready);
  assign wr_fire     = slot_full_q && wr_ready;
  assign cmp_data    = active ? buf_q[127:0] : 128'd0;
  assign cmp_start   = cmp_start_q;
  assign wr_en       = slot_full_q;
  assign wr_data     = slot_q;
  assign wr_addr     = wr_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign pkt_count   = pkt_count_q;

  // Control state: FSM, occupancy, byte accounting, write address and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      occ_q       <= 6'd0;
      total_q     <= 16'd0;
      rcvd_q      <= 16'd0;
      slot_full_q <= 1'b0;
      wr_addr_q   <= '0;
      pkt_count_q <= 16'd0;
      cmp_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      cmp_start_q <= start_acc;
      if (start_acc) begin
        total_q <= total_bytes;
        rcvd_q  <= 16'd0;
      end else begin
        rcvd_q  <= rcvd_d;
      end
      if (cmp_mem_ack)  slot_full_q <= 1'b1;
      else if (wr_fire) slot_full_q <= 1'b0;
      if (start_acc) begin
        wr_addr_q   <= base_addr;
        pkt_count_q <= 16'd0;
      end else if (wr_fire) begin
        wr_addr_q   <= wr_addr_q + 1'b1;
        pkt_count_q <= sat_inc16(pkt_count_q);
      end
    end
  end

  // Data state: byte window and packet slot, cleared so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      slot_q <= 64'd0;
    end else begin
      buf_q <= buf_d;
      if (cmp_mem_ack) slot_q <= cmp_packet;
    end
  end

endmodule

// File: tb/tb_compress_seq.sv
// Bench for compress_seq: directed scenarios plus randomized layers checked
// against a queue-based behavioural model of the window, slot and layer phases.
module tb_compress_seq;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, cmp_mem_req, wr_ready;
  logic [15:0]  total_bytes, base_addr, wr_addr, pkt_count;
  logic [127:0] in_data, cmp_data;
  logic [4:0]   in_num, cmp_valid_num, cmp_taken;
  logic [63:0]  cmp_packet, wr_data;
  logic         in_ready, cmp_start, cmp_mem_ack, wr_en, busy, done;

  int n_vec = 0;
  int n_err = 0;

  compress_seq #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .total_bytes(total_bytes),
    .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_num(in_num), .cmp_data(cmp_data),
    .cmp_valid_num(cmp_valid_num), .cmp_start(cmp_start), .cmp_taken(cmp_taken),
    .cmp_mem_req(cmp_mem_req), .cmp_packet(cmp_packet), .cmp_mem_ack(cmp_mem_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 receiving, 2 draining, 3 finished
  int           m_phase = 0;
  byte unsigned m_q[$];
  int           m_total = 0, m_rcvd = 0, m_cnt = 0;
  bit           m_slot_full = 0, m_cstart = 0;
  logic [63:0]  m_slot = '0;
  logic [15:0]  m_addr = '0;
  bit           e_in_ready, e_ack;
  int           e_cvn;
  logic [127:0] e_cmp_data;

  task automatic model_outputs();
    e_in_ready = (m_phase == 1) && (m_q.size() <= 16) && (m_rcvd < m_total);
    e_cvn = (m_phase == 1 || m_phase == 2) ? ((m_q.size() > 16) ? 16 : m_q.size()) : 0;
    e_cmp_data = '0;
    for (int i = 0; i < e_cvn; i++) e_cmp_data[8*i +: 8] = m_q[i];
    e_ack = cmp_mem_req && (!m_slot_full || wr_ready);
  endtask

  task automatic model_step();
    int take, n;
    bit drain_ok, fire, idle_start;
    model_outputs();
    if (rst) begin
      m_phase = 0; m_q.delete(); m_total = 0; m_rcvd = 0; m_cnt = 0;
      m_slot_full = 0; m_cstart = 0; m_slot = '0; m_addr = '0;
      return;
    end
    take       = (int'(cmp_taken) < e_cvn) ? int'(cmp_taken) : e_cvn;
    drain_ok   = (m_q.size() == 0) && !cmp_mem_req && !m_slot_full;
    fire       = m_slot_full && wr_ready;
    idle_start = (m_phase == 0) && start;
    repeat (take) void'(m_q.pop_front());
    if (in_valid && e_in_ready) begin
      n = (in_num > 16) ? 16 : int'(in_num);
      if (n > m_total - m_rcvd) n = m_total - m_rcvd;
      for (int i = 0; i < n; i++) m_q.push_back(in_data[8*i +: 8]);
      m_rcvd += n;
    end
    m_cstart = idle_start;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_total = int'(total_bytes); m_rcvd = 0; end
      1: if (m_rcvd == m_total) m_phase = 2;
      2: if (drain_ok) m_phase = 3;
      default: m_phase = 0;
    endcase
    if (idle_start) begin
      m_addr = base_addr; m_cnt = 0;
    end else if (fire) begin
      m_addr = m_addr + 16'd1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (e_ack) begin m_slot = cmp_packet; m_slot_full = 1; end
    else if (fire) m_slot_full = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; in_valid = 0; in_num = 5'd1; in_data = '0; cmp_taken = 0;
    cmp_mem_req = 0; cmp_packet = '0; wr_ready = 0;
  endtask

  task automatic begin_layer(input logic [15:0] tot, input logic [15:0] base);
    start = 1; total_bytes = tot; base_addr = base;
    tick();
    start = 0;
  endtask

  task automatic finish_layer(output bit seen);
    seen = 0; start = 0; in_valid = 0; cmp_mem_req = 0; cmp_taken = 5'd16; wr_ready = 1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (done === 1'b1) seen = 1;
      if (seen && busy === 1'b0) break;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs(); rst = 1; total_bytes = 0; base_addr = 0;
    tick(); tick(); #1;
    n_vec++;
    if ({in_ready, cmp_valid_num, cmp_start, cmp_mem_ack, wr_en, busy, done} !== 11'd0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0", {in_ready, cmp_valid_num, cmp_start, cmp_mem_ack, wr_en, busy, done});
    end
    n_vec++;
    if (cmp_data !== 128'd0) begin n_err++; $display("FAIL reset_cmp_data: got %h want 0", cmp_data); end
    n_vec++;
    if ({wr_addr, wr_data, pkt_count} !== 96'd0) begin
      n_err++; $display("FAIL reset_wr: got %h want 0", {wr_addr, wr_data, pkt_count});
    end
    rst = 0;
  endtask

  task automatic test_basic();
    int beats = 0, dones = 0;
    logic [10:0] exp_ctl, got_ctl;
    idle_inputs(); cmp_taken = 5'd16;
    begin_layer(16'd32, 16'h0100);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1; in_num = 5'd16; in_data = {$urandom, $urandom, $urandom, $urandom};
      #1; model_outputs();
      exp_ctl = {e_in_ready, 5'(e_cvn), m_cstart, e_ack, m_slot_full, m_phase != 0, m_phase == 3};
      got_ctl = {in_ready, cmp_valid_num, cmp_start, cmp_mem_ack, wr_en, busy, done};
      n_vec++;
      if (got_ctl !== exp_ctl) begin n_err++; $display("FAIL basic_ctl c%0d: got %b want %b", c, got_ctl, exp_ctl); end
      n_vec++;
      if (cmp_data !== e_cmp_data) begin n_err++; $display("FAIL basic_data c%0d: got %h want %h", c, cmp_data, e_cmp_data); end
      if (in_ready === 1'b1) beats++;
      if (done === 1'b1) dones++;
      tick();
    end
    in_valid = 0; #1;
    n_vec++; if (beats != 2) begin n_err++; $display("FAIL basic_beats: got %0d want 2", beats); end
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", dones); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_shift();
    logic [127:0] a, b, cb;
    bit seen;
    idle_inputs();
    begin_layer(16'd25, 16'h0000);
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    cb = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1; in_num = 5'd16; in_data = a; tick();
    in_num = 5'd4; in_data = b; tick();
    in_num = 5'd5; in_data = cb; cmp_taken = 5'd7; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL shift_ready_occ20: got %b want 0", in_ready); end
    n_vec++; if (cmp_valid_num !== 5'd16) begin n_err++; $display("FAIL shift_cvn_occ20: got %0d want 16", cmp_valid_num); end
    tick();
    cmp_taken = 5'd0; #1;
    n_vec++; if (cmp_valid_num !== 5'd13) begin n_err++; $display("FAIL shift_cvn_after_take: got %0d want 13", cmp_valid_num); end
    n_vec++; if (cmp_data[7:0] !== a[63:56]) begin n_err++; $display("FAIL shift_byte0: got %h want %h", cmp_data[7:0], a[63:56]); end
    n_vec++; if (cmp_data[103:96] !== b[31:24]) begin n_err++; $display("FAIL shift_lane12: got %h want %h", cmp_data[103:96], b[31:24]); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL shift_ready_occ13: got %b want 1", in_ready); end
    tick();
    in_valid = 0; #1;
    n_vec++; if (cmp_valid_num !== 5'd16) begin n_err++; $display("FAIL shift_cvn_occ18: got %0d want 16", cmp_valid_num); end
    n_vec++; if (cmp_data[111:104] !== cb[7:0]) begin n_err++; $display("FAIL shift_append: got %h want %h", cmp_data[111:104], cb[7:0]); end
    finish_layer(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL shift_done: got no done want done"); end
  endtask

  task automatic test_packets();
    logic [63:0] p1, p2;
    bit seen;
    idle_inputs();
    begin_layer(16'd0, 16'h0100);
    p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom};
    cmp_mem_req = 1; cmp_packet = p1; wr_ready = 0; #1;
    n_vec++; if ({cmp_mem_ack, wr_en} !== 2'b10) begin n_err++; $display("FAIL pkt_first_ack: got %b want 10", {cmp_mem_ack, wr_en}); end
    tick();
    cmp_packet = p2;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if ({cmp_mem_ack, wr_en} !== 2'b01) begin n_err++; $display("FAIL pkt_stall c%0d: got %b want 01", c, {cmp_mem_ack, wr_en}); end
      n_vec++; if ({wr_addr, wr_data} !== {16'h0100, p1}) begin n_err++; $display("FAIL pkt_stall_wr c%0d: got %h want %h", c, {wr_addr, wr_data}, {16'h0100, p1}); end
      tick();
    end
    wr_ready = 1; #1;
    n_vec++; if ({cmp_mem_ack, wr_en} !== 2'b11) begin n_err++; $display("FAIL pkt_ack_and_write: got %b want 11", {cmp_mem_ack, wr_en}); end
    tick();
    cmp_mem_req = 0; #1;
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0101, p2}) begin n_err++; $display("FAIL pkt_second_write: got %h want %h", {wr_en, wr_addr, wr_data}, {1'b1, 16'h0101, p2}); end
    n_vec++; if (pkt_count !== 16'd1) begin n_err++; $display("FAIL pkt_count1: got %0d want 1", pkt_count); end
    tick(); #1;
    n_vec++; if ({wr_en, wr_addr, pkt_count} !== {1'b0, 16'h0102, 16'd2}) begin n_err++; $display("FAIL pkt_after: got %h want %h", {wr_en, wr_addr, pkt_count}, {1'b0, 16'h0102, 16'd2}); end
    finish_layer(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL pkt_done: got no done want done"); end
  endtask

  task automatic test_truncate();
    logic [127:0] d;
    bit seen;
    idle_inputs();
    begin_layer(16'd10, 16'h0000);
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1; in_num = 5'd16; in_data = d; #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL trunc_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0; cmp_taken = 5'd16; #1;
    n_vec++; if (cmp_valid_num !== 5'd10) begin n_err++; $display("FAIL trunc_cvn: got %0d want 10", cmp_valid_num); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL trunc_ready_after: got %b want 0", in_ready); end
    n_vec++; if (cmp_data !== {48'd0, d[79:0]}) begin n_err++; $display("FAIL trunc_data: got %h want %h", cmp_data, {48'd0, d[79:0]}); end
    tick(); #1;
    n_vec++; if ({done, cmp_valid_num} !== 6'd0) begin n_err++; $display("FAIL trunc_drained: got %b want 0", {done, cmp_valid_num}); end
    tick(); #1;
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL trunc_done_timing: got %b want 1", done); end
    finish_layer(seen);
  endtask

  task automatic test_wrap();
    logic [63:0] p1, p2;
    bit seen;
    idle_inputs();
    begin_layer(16'd0, 16'hFFFF);
    p1 = {$urandom, $urandom}; p2 = {$urandom, $urandom};
    wr_ready = 1; cmp_mem_req = 1; cmp_packet = p1; #1;
    n_vec++; if (cmp_mem_ack !== 1'b1) begin n_err++; $display("FAIL wrap_ack1: got %b want 1", cmp_mem_ack); end
    tick();
    cmp_packet = p2; #1;
    n_vec++; if ({cmp_mem_ack, wr_en, wr_addr} !== {2'b11, 16'hFFFF}) begin n_err++; $display("FAIL wrap_addr_max: got %h want %h", {cmp_mem_ack, wr_en, wr_addr}, {2'b11, 16'hFFFF}); end
    tick();
    cmp_mem_req = 0; #1;
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0000, p2}) begin n_err++; $display("FAIL wrap_addr_zero: got %h want %h", {wr_en, wr_addr, wr_data}, {1'b1, 16'h0000, p2}); end
    tick(); #1;
    n_vec++; if ({wr_en, pkt_count} !== {1'b0, 16'd2}) begin n_err++; $display("FAIL wrap_count: got %h want %h", {wr_en, pkt_count}, {1'b0, 16'd2}); end
    finish_layer(seen);
    n_vec++; if (!seen) begin n_err++; $display("FAIL wrap_done: got no done want done"); end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    begin_layer(16'd40, 16'h0200);
    in_valid = 1; in_num = 5'd12; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 0; cmp_mem_req = 1; cmp_packet = {$urandom, $urandom};
    tick();
    cmp_mem_req = 0; #1;
    n_vec++; if ({cmp_valid_num, wr_en} !== {5'd12, 1'b1}) begin n_err++; $display("FAIL midrst_pre: got %b want %b", {cmp_valid_num, wr_en}, {5'd12, 1'b1}); end
    rst = 1;
    tick(); #1;
    n_vec++;
    if ({in_ready, cmp_valid_num, cmp_start, cmp_mem_ack, wr_en, busy, done} !== 11'd0) begin
      n_err++; $display("FAIL midrst_ctl: got %b want 0", {in_ready, cmp_valid_num, cmp_start, cmp_mem_ack, wr_en, busy, done});
    end
    n_vec++;
    if ({cmp_data, wr_addr, wr_data, pkt_count} !== 224'd0) begin
      n_err++; $display("FAIL midrst_data: got %h want 0", {cmp_data, wr_addr, wr_data, pkt_count});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_random(input int layers);
    logic [10:0] exp_ctl, got_ctl;
    for (int l = 0; l < layers; l++) begin
      idle_inputs();
      begin_layer(($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 90)), 16'($urandom));
      for (int c = 0; c < 600; c++) begin
        if (m_phase == 0) break;
        start       = ($urandom_range(0, 7) == 0);
        total_bytes = 16'($urandom);
        base_addr   = 16'($urandom);
        in_valid    = ($urandom_range(0, 2) != 0);
        in_num      = 5'($urandom_range(1, 16));
        in_data     = {$urandom, $urandom, $urandom, $urandom};
        cmp_taken   = 5'($urandom_range(0, 18));
        cmp_mem_req = ($urandom_range(0, 9) < 3);
        cmp_packet  = {$urandom, $urandom};
        wr_ready    = 1'($urandom_range(0, 1));
        #1; model_outputs();
        exp_ctl = {e_in_ready, 5'(e_cvn), m_cstart, e_ack, m_slot_full, m_phase != 0, m_phase == 3};
        got_ctl = {in_ready, cmp_valid_num, cmp_start, cmp_mem_ack, wr_en, busy, done};
        n_vec++;
        if (got_ctl !== exp_ctl) begin n_err++; $display("FAIL rand_ctl l%0d c%0d: got %b want %b", l, c, got_ctl, exp_ctl); end
        n_vec++;
        if (cmp_data !== e_cmp_data) begin n_err++; $display("FAIL rand_data l%0d c%0d: got %h want %h", l, c, cmp_data, e_cmp_data); end
        n_vec++;
        if ({wr_addr, wr_data, pkt_count} !== {m_addr, m_slot, 16'(m_cnt)}) begin
          n_err++; $display("FAIL rand_wr l%0d c%0d: got %h want %h", l, c, {wr_addr, wr_data, pkt_count}, {m_addr, m_slot, 16'(m_cnt)});
        end
        tick();
      end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL rand_timeout l%0d: busy got %b want 0", l, busy); end
      if (n_err > 20) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs(); rst = 1; total_bytes = 0; base_addr = 0;
    test_reset();
    test_basic();
    test_shift();
    test_packets();
    test_truncate();
    test_wrap();
    test_mid_reset();
    test_basic();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
